// File: rtl/fdiv_if.sv
// Bundle of signals between a divided-clock source and the fdiv_monitor.
// There is no backpressure on this bus. The monitor drives valid for
// exactly one clk cycle whenever it publishes a new
// period/high_cnt/low_cnt triple. The consumer must take the triple in
// that cycle, because the monitor never waits.
interface fdiv_if #(
  parameter int CNT_W = 8
);
  logic             div_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic             valid;
  logic             err;
  logic             locked;
  logic             stuck;
  logic             state_dbg;

  modport master (
    output div_in,
    input  period, high_cnt, low_cnt, valid, err, locked, stuck, state_dbg
  );

  modport slave (
    input  div_in,
    output period, high_cnt, low_cnt, valid, err, locked, stuck, state_dbg
  );
endinterface

// File: rtl/fdiv_monitor.sv
// Divided-clock checker. The monitor samples div_in as data in the clk
// domain and measures the high, low and total cycle counts of each period.
// It flags a ratio mismatch, lock after LOCK_N good periods, and a stuck
// input when no rising edge arrives for TIMEOUT cycles.
module fdiv_monitor #(
  parameter int CNT_W   = 8,
  parameter int EXP_DIV = 2,
  parameter int LOCK_N  = 4,
  parameter int TIMEOUT = 32
) (
  input  logic   clk,
  input  logic   rst,
  fdiv_if.slave  bus
);
  localparam logic [0:0]       S_IDLE   = 1'b0;
  localparam logic [0:0]       S_MEAS   = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   EXP_W    = (CNT_W + 1)'(EXP_DIV);
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_N);

  logic [0:0]       state_q, state_d;
  logic             d_q, d_d;
  logic [CNT_W-1:0] hc_q, hc_d, lc_q, lc_d, tcnt_q, tcnt_d;
  logic [3:0]       match_q, match_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d, low_q, low_d;
  logic             valid_q, valid_d, err_q, err_d;
  logic             locked_q, locked_d, stuck_q, stuck_d;
  logic             rise, timeout;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] sum_sat;

  // Edge detect, timeout condition and the saturated period sum.
  always_comb begin
    rise    = bus.div_in & ~d_q;
    timeout = ~rise & (tcnt_q >= TO_LAST);
    sum     = {1'b0, hc_q} + {1'b0, lc_q};
    sum_sat = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  end

  // Running high/low counters and the cycles-since-last-rise counter.
  // The rise cycle itself counts as the first high cycle.
  always_comb begin
    d_d  = bus.div_in;
    hc_d = hc_q;
    lc_d = lc_q;
    if (rise) begin
      hc_d = CNT_W'(1);
      lc_d = '0;
    end else if (bus.div_in) begin
      if (hc_q != CNT_MAX) hc_d = hc_q + 1'b1;
    end else begin
      if (lc_q != CNT_MAX) lc_d = lc_q + 1'b1;
    end
    if (rise)                 tcnt_d = '0;
    else if (tcnt_q != CNT_MAX) tcnt_d = tcnt_q + 1'b1;
    else                      tcnt_d = tcnt_q;
  end

  // Measurement FSM. A rise takes priority over a timeout in the same cycle.
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    period_d = period_q;
    high_d   = high_q;
    low_d    = low_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    stuck_d  = stuck_q;
    if (rise) begin
      if (state_q == S_IDLE) begin
        state_d = S_MEAS;
        stuck_d = 1'b0;
      end else begin
        high_d   = hc_q;
        low_d    = lc_q;
        period_d = sum_sat;
        valid_d  = 1'b1;
        if (sum == EXP_W) begin
          if (match_q != LOCK_TGT) match_d = match_q + 1'b1;
          if (match_d == LOCK_TGT) locked_d = 1'b1;
        end else begin
          err_d    = 1'b1;
          match_d  = '0;
          locked_d = 1'b0;
        end
      end
    end else if (timeout) begin
      stuck_d  = 1'b1;
      locked_d = 1'b0;
      match_d  = '0;
      state_d  = S_IDLE;
    end
  end

  // State register. d_q resets high so that an input already high at
  // reset release does not count as a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      d_q      <= 1'b1;
      hc_q     <= '0;
      lc_q     <= '0;
      tcnt_q   <= '0;
      match_q  <= '0;
      period_q <= '0;
      high_q   <= '0;
      low_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      hc_q     <= hc_d;
      lc_q     <= lc_d;
      tcnt_q   <= tcnt_d;
      match_q  <= match_d;
      period_q <= period_d;
      high_q   <= high_d;
      low_q    <= low_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      stuck_q  <= stuck_d;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_cnt  = high_q;
  assign bus.low_cnt   = low_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.locked    = locked_q;
  assign bus.stuck     = stuck_q;
  assign bus.state_dbg = state_q[0];
endmodule

// File: tb/tb_fdiv_monitor.sv
// Bench for fdiv_monitor. Two instances share one div_in:
// instance a has EXP_DIV=2 and LOCK_N=4, and instance b has EXP_DIV=4
// and LOCK_N=2. The reference model keeps, for each instance, the
// number of samples and the number of high samples since the last rising
// edge, and derives the expected outputs from those counts.
module tb_fdiv_monitor;
  localparam int W  = 8;
  localparam int TO = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic div = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // clock
  always #5 clk = ~clk;

  fdiv_if #(.CNT_W(W)) bus_a ();
  fdiv_if #(.CNT_W(W)) bus_b ();
  assign bus_a.div_in = div;
  assign bus_b.div_in = div;

  fdiv_monitor #(.CNT_W(W), .EXP_DIV(2), .LOCK_N(4), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  fdiv_monitor #(.CNT_W(W), .EXP_DIV(4), .LOCK_N(2), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  wire [27:0] got_a = {bus_a.valid, bus_a.err, bus_a.locked, bus_a.stuck,
                       bus_a.period, bus_a.high_cnt, bus_a.low_cnt};
  wire [27:0] got_b = {bus_b.valid, bus_b.err, bus_b.locked, bus_b.stuck,
                       bus_b.period, bus_b.high_cnt, bus_b.low_cnt};

  // reference model state, indexed by instance
  int m_exp[2]   = '{2, 4};
  int m_lockn[2] = '{4, 2};
  bit m_prev[2], m_meas[2], m_valid[2], m_err[2], m_locked[2], m_stuck[2];
  int m_len[2], m_ones[2], m_since[2], m_match[2];
  int m_period[2], m_high[2], m_low[2];

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [27:0] exp_vec(input int i);
    return {m_valid[i], m_err[i], m_locked[i], m_stuck[i],
            8'(m_period[i]), 8'(m_high[i]), 8'(m_low[i])};
  endfunction

  task automatic model_step(input int i, input bit s, input bit r);
    bit rise;
    m_valid[i] = 1'b0;
    m_err[i]   = 1'b0;
    if (r) begin
      m_prev[i] = 1'b1; m_meas[i] = 1'b0; m_locked[i] = 1'b0; m_stuck[i] = 1'b0;
      m_len[i] = 0; m_ones[i] = 0; m_since[i] = 0; m_match[i] = 0;
      m_period[i] = 0; m_high[i] = 0; m_low[i] = 0;
      return;
    end
    rise = s && !m_prev[i];
    m_prev[i] = s;
    if (rise) begin
      if (m_meas[i]) begin
        m_valid[i]  = 1'b1;
        m_period[i] = sat(m_len[i]);
        m_high[i]   = sat(m_ones[i]);
        m_low[i]    = sat(m_len[i] - m_ones[i]);
        if (m_len[i] == m_exp[i]) begin
          if (m_match[i] < m_lockn[i]) m_match[i]++;
          if (m_match[i] == m_lockn[i]) m_locked[i] = 1'b1;
        end else begin
          m_err[i] = 1'b1; m_match[i] = 0; m_locked[i] = 1'b0;
        end
      end else begin
        m_meas[i]  = 1'b1;
        m_stuck[i] = 1'b0;
      end
      m_len[i] = 1; m_ones[i] = 1; m_since[i] = 0;
    end else begin
      m_len[i]++;
      m_ones[i] += int'(s);
      m_since[i]++;
      if (m_since[i] >= TO) begin
        m_stuck[i] = 1'b1; m_locked[i] = 1'b0; m_match[i] = 0; m_meas[i] = 1'b0;
      end
    end
  endtask

  // driver: present one sample, let the DUT take it, advance the model
  task automatic step(input bit s, input bit r);
    @(negedge clk);
    div = s;
    rst = r;
    @(posedge clk);
    #1;
    model_step(0, s, r);
    model_step(1, s, r);
    cyc++;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    n_checks++;
    if (got_a !== 28'h0) begin n_fail++; $display("FAIL reset_a cyc=%0d got=%h exp=%h", cyc, got_a, 28'h0); end
    n_checks++;
    if (got_b !== 28'h0) begin n_fail++; $display("FAIL reset_b cyc=%0d got=%h exp=%h", cyc, got_b, 28'h0); end
  endtask

  task automatic test_div2();
    int nv = 0;
    for (int k = 0; k < 20; k++) begin
      step(k % 2 == 1, 1'b0);
      n_checks++;
      if (got_a !== exp_vec(0)) begin n_fail++; $display("FAIL div2_a cyc=%0d got=%h exp=%h", cyc, got_a, exp_vec(0)); end
      n_checks++;
      if (got_b !== exp_vec(1)) begin n_fail++; $display("FAIL div2_b cyc=%0d got=%h exp=%h", cyc, got_b, exp_vec(1)); end
      if (m_valid[0]) begin
        nv++;
        n_checks++;
        if (bus_a.locked !== (nv >= 4)) begin
          n_fail++; $display("FAIL div2_lock nv=%0d got=%b exp=%b", nv, bus_a.locked, nv >= 4);
        end
      end
    end
  endtask

  task automatic test_div4();
    bit first = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step(((j + 1) % 4) < 2, 1'b0);
      n_checks++;
      if (got_a !== exp_vec(0)) begin n_fail++; $display("FAIL div4_a cyc=%0d got=%h exp=%h", cyc, got_a, exp_vec(0)); end
      n_checks++;
      if (got_b !== exp_vec(1)) begin n_fail++; $display("FAIL div4_b cyc=%0d got=%h exp=%h", cyc, got_b, exp_vec(1)); end
      if (m_valid[0] && first) begin
        first = 1'b0;
        n_checks++;
        if ({bus_a.period, bus_a.high_cnt, bus_a.low_cnt, bus_a.err, bus_a.locked} !== {8'd4, 8'd2, 8'd2, 1'b1, 1'b0}) begin
          n_fail++; $display("FAIL div4_first got p=%0d h=%0d l=%0d err=%b lock=%b exp p=4 h=2 l=2 err=1 lock=0",
                             bus_a.period, bus_a.high_cnt, bus_a.low_cnt, bus_a.err, bus_a.locked);
        end
      end
    end
  endtask

  task automatic test_skew();
    int nv = 0;
    step(1'b0, 1'b1);
    for (int j = 0; j < 25; j++) begin
      step((j == 0) ? 1'b0 : (((j - 1) % 4) != 3), 1'b0);
      n_checks++;
      if (got_a !== exp_vec(0)) begin n_fail++; $display("FAIL skew_a cyc=%0d got=%h exp=%h", cyc, got_a, exp_vec(0)); end
      n_checks++;
      if (got_b !== exp_vec(1)) begin n_fail++; $display("FAIL skew_b cyc=%0d got=%h exp=%h", cyc, got_b, exp_vec(1)); end
      if (m_valid[1]) begin
        nv++;
        n_checks++;
        if ({bus_b.period, bus_b.high_cnt, bus_b.low_cnt, bus_b.err, bus_b.locked} !== {8'd4, 8'd3, 8'd1, 1'b0, nv >= 2}) begin
          n_fail++; $display("FAIL skew_meas nv=%0d got p=%0d h=%0d l=%0d err=%b lock=%b exp p=4 h=3 l=1 err=0 lock=%b",
                             nv, bus_b.period, bus_b.high_cnt, bus_b.low_cnt, bus_b.err, bus_b.locked, nv >= 2);
        end
      end
    end
  endtask

  task automatic test_stuck();
    for (int k = 0; k < 12; k++) begin
      step(k % 2 == 1, 1'b0);
      n_checks++;
      if (got_a !== exp_vec(0)) begin n_fail++; $display("FAIL relock_a cyc=%0d got=%h exp=%h", cyc, got_a, exp_vec(0)); end
    end
    for (int h = 1; h <= 40; h++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (got_a !== exp_vec(0)) begin n_fail++; $display("FAIL stuck_a cyc=%0d got=%h exp=%h", cyc, got_a, exp_vec(0)); end
      n_checks++;
      if (got_b !== exp_vec(1)) begin n_fail++; $display("FAIL stuck_b cyc=%0d got=%h exp=%h", cyc, got_b, exp_vec(1)); end
      if (h == 31 || h == 32) begin
        n_checks++;
        if ({bus_a.stuck, bus_a.locked} !== {h == 32, h == 31}) begin
          n_fail++; $display("FAIL stuck_edge h=%0d got stuck=%b lock=%b exp stuck=%b lock=%b",
                             h, bus_a.stuck, bus_a.locked, h == 32, h == 31);
        end
      end
    end
    step(1'b1, 1'b0);
    n_checks++;
    if ({bus_a.stuck, bus_a.valid} !== 2'b00) begin n_fail++; $display("FAIL unstick got stuck=%b valid=%b exp 0 0", bus_a.stuck, bus_a.valid); end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_checks++;
    if ({bus_a.valid, bus_a.period} !== {1'b1, 8'd2}) begin
      n_fail++; $display("FAIL after_stuck got valid=%b p=%0d exp valid=1 p=2", bus_a.valid, bus_a.period);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 12; k++) step(k % 2 == 0, 1'b0);
    n_checks++;
    if (bus_a.locked !== 1'b1) begin n_fail++; $display("FAIL premid_lock got=%b exp=1", bus_a.locked); end
    step(1'b1, 1'b1);
    n_checks++;
    if (got_a !== 28'h0) begin n_fail++; $display("FAIL mid_rst_a got=%h exp=%h", got_a, 28'h0); end
    for (int k = 0; k < 12; k++) begin
      step((k < 3) ? 1'b1 : (k % 2 == 0), 1'b0);
      n_checks++;
      if (got_a !== exp_vec(0)) begin n_fail++; $display("FAIL mid_a cyc=%0d got=%h exp=%h", cyc, got_a, exp_vec(0)); end
      n_checks++;
      if (got_b !== exp_vec(1)) begin n_fail++; $display("FAIL mid_b cyc=%0d got=%h exp=%h", cyc, got_b, exp_vec(1)); end
    end
  endtask

  task automatic test_reset_high();
    step(1'b1, 1'b1);
    for (int k = 0; k < 22; k++) begin
      step((k < 2) ? 1'b1 : (k % 2 == 1), 1'b0);
      n_checks++;
      if (got_a !== exp_vec(0)) begin n_fail++; $display("FAIL rsthi_a cyc=%0d got=%h exp=%h", cyc, got_a, exp_vec(0)); end
      n_checks++;
      if (got_b !== exp_vec(1)) begin n_fail++; $display("FAIL rsthi_b cyc=%0d got=%h exp=%h", cyc, got_b, exp_vec(1)); end
    end
  endtask

  task automatic test_random();
    bit seq[$];
    int h, l;
    for (int p = 0; p < 80; p++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin h = 1; l = 1; end
        4, 5:       begin h = $urandom_range(1, 3); l = 4 - h; end
        6:          begin h = $urandom_range(1, 3); l = 34; end
        default:    begin h = $urandom_range(1, 5); l = $urandom_range(1, 5); end
      endcase
      for (int k = 0; k < h; k++) seq.push_back(1'b1);
      for (int k = 0; k < l; k++) seq.push_back(1'b0);
    end
    foreach (seq[k]) begin
      step(seq[k], 1'b0);
      n_checks++;
      if (got_a !== exp_vec(0)) begin n_fail++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", cyc, got_a, exp_vec(0)); end
      n_checks++;
      if (got_b !== exp_vec(1)) begin n_fail++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", cyc, got_b, exp_vec(1)); end
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_div4();
    test_skew();
    test_stuck();
    test_reset_mid();
    test_reset_high();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fdiv_monitor.md
Name: fdiv_monitor

Overview:
- Checker/receiver for a divided clock produced by the team's frequency-divider blocks.
- Samples a divided clock as a data signal in the source clock domain and measures each period's high time, low time and total length in source-clock cycles.
- Flags lock, mismatch against an expected divide ratio, and stuck input.
- Used in-system and in benches to verify divider outputs cycle-accurately.

Parameters:
- CNT_W, 8, width of all cycle counters and measurement outputs.
- EXP_DIV, 2, expected period of div_in in clk cycles.
- LOCK_N, 4, consecutive matching periods required to assert locked; range 1..15.
- TIMEOUT, 32, cycles without a rising edge before stuck is declared; must be < 2^CNT_W-1.

Ports:
- clk  input  1  source clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- div_in  input  1  divided clock under test, launched from clk.
- period  output  CNT_W  last measured period (high_cnt+low_cnt).
- high_cnt  output  CNT_W  sampled-high cycles of the last period.
- low_cnt  output  CNT_W  sampled-low cycles of the last period.
- valid  output  1  one-cycle pulse; period/high_cnt/low_cnt updated.
- err  output  1  one-cycle pulse, coincident with valid, when period != EXP_DIV.
- locked  output  1  level; LOCK_N consecutive periods == EXP_DIV.
- stuck  output  1  level; no rising edge for TIMEOUT cycles.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; period, high_cnt, low_cnt, valid, err, locked, stuck = 0; internal counters = 0; edge register d_q=1, so a div_in already high at release is not treated as a rising edge. Reset has priority over all events and aborts any measurement in progress.
- Edge detect: rise = div_in & ~d_q each posedge; d_q <= div_in.
- Running counters hc and lc:
  - On rise: hc<=1, lc<=0.
  - Otherwise: hc increments if div_in=1, lc increments if div_in=0.
  - Both saturate at 2^CNT_W-1.
- State IDLE: wait for rise. On rise: go to MEAS, start counters, clear stuck. No valid is produced.
- State MEAS, on rise:
  - Outputs register in the same posedge: high_cnt<=hc, low_cnt<=lc, period<=hc+lc, saturated at 2^CNT_W-1.
  - valid=1 for exactly that cycle (visible the cycle after the rise is sampled).
  - If hc+lc == EXP_DIV: match_cnt increments, saturating at LOCK_N; locked<=1 once match_cnt reaches LOCK_N.
  - Else: err=1 for that cycle; match_cnt<=0; locked<=0.
  - State stays MEAS.
- Timeout, in MEAS or IDLE: the cycles-since-last-rise counter reaches TIMEOUT without a rise → stuck<=1, locked<=0, match_cnt<=0, state<=IDLE. Measurement outputs hold their last values; no valid.
- Priority in the same cycle: rise beats timeout.
- valid and err are 0 in every cycle not described above.
- Measured values are exact for waveforms synchronous to clk. Periods longer than TIMEOUT are never reported.

Test Plan:
- Divide-by-2 stimulus (div_in toggles every clk), EXP_DIV=2, LOCK_N=4 → first rise gives no valid; then valid every 2 cycles with period=2, high_cnt=1, low_cnt=1, err=0; locked=1 in the cycle of the 4th valid.
- Locked at div-2, then switch to divide-by-4 (2 high/2 low) → first new valid shows period=4, high_cnt=2, low_cnt=2, err=1, locked=0; locked remains 0.
- Duty-skewed period (3 high, 1 low), EXP_DIV=4, LOCK_N=2 → period=4, high_cnt=3, low_cnt=1; locked after 2nd valid; err never set.
- Hold div_in=0 after lock, TIMEOUT=32 → stuck=1 and locked=0 exactly 32 cycles after the last rise. The next rise clears stuck without valid; the following rise gives valid.
- rst=1 for one cycle mid-period while locked with div_in=1 → all outputs 0 next cycle. The held-high input produces no rise; the first valid comes only after two genuine 0→1 transitions.
- div_in high at reset release, then divide-by-2 → no spurious valid or err; behaviour is identical to the first scenario, offset by one edge.
